// File: rtl/k2_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : k2_fetch_unit
// Purpose  : K2 instruction fetch stage: PC, instruction register, next-PC select
// Revision : 1.0
// ============================================================================
module k2_fetch_unit #(
  parameter int ADDR_W    = 4,
  parameter int INST_W    = 8,
  parameter int LAST_ADDR = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] s,
  input  logic [INST_W-1:0] rom_data,
  input  logic              jump_req,
  input  logic              jump_cond,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic [INST_W-1:0] ir,
  output logic              ir_valid,
  output logic              halted,
  output logic              addr_err,
  output logic [7:0]        retired
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(LAST_ADDR);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INST_W-1:0]   r_ir;
  logic                r_ir_valid;
  logic                r_halted;
  logic                r_addr_err;
  logic [7:0]          r_retired;

  logic                w_tgt_bad;
  logic [ADDR_W-1:0]   w_pc_seq;

  assign w_tgt_bad = (jump_target > c_last_addr);
  assign w_pc_seq  = (r_pc == c_last_addr) ? '0 : r_pc + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_addr_err <= 1'b0;
      r_retired  <= '0;
    end else if (en) begin
      case (r_state)
        ST_FETCH: begin
          r_ir       <= rom_data;
          r_ir_valid <= 1'b1;
          r_addr_err <= 1'b0;
          r_state    <= ST_EXEC;
        end
        ST_EXEC: begin
          r_ir_valid <= 1'b0;
          if (r_retired != 8'hFF) begin
            r_retired <= r_retired + 8'd1;
          end
          // Halt outranks a taken jump: the PC is left pointing at the halting instruction.
          if (halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALTED;
          end else if (jump_req && jump_cond) begin
            r_pc       <= w_tgt_bad ? '0 : jump_target;
            r_addr_err <= w_tgt_bad;
            r_state    <= ST_FETCH;
          end else begin
            r_pc    <= w_pc_seq;
            r_state <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  // The error pulse is hidden while stalled so it is never seen stretched.
  assign addr_err = r_addr_err & en;
  assign s        = r_pc;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign halted   = r_halted;
  assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_k2_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_k2_fetch_unit
// Purpose  : Scoreboard bench for k2_fetch_unit (sequencing, jumps, halt, stalls, reset)
// Revision : 1.0
// ============================================================================
module tb_k2_fetch_unit;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] s;
  logic [7:0] rom_data;
  logic       jump_req;
  logic       jump_cond;
  logic [3:0] jump_target;
  logic       halt;
  logic [7:0] ir;
  logic       ir_valid;
  logic       halted;
  logic       addr_err;
  logic [7:0] retired;

  k2_fetch_unit #(.ADDR_W(4), .INST_W(8), .LAST_ADDR(9)) dut (
    .clk(clk), .reset(reset), .en(en), .s(s), .rom_data(rom_data),
    .jump_req(jump_req), .jump_cond(jump_cond), .jump_target(jump_target),
    .halt(halt), .ir(ir), .ir_valid(ir_valid), .halted(halted),
    .addr_err(addr_err), .retired(retired)
  );

  logic [7:0] rom [16];
  assign rom_data = rom[s];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ir;
  } sb_t;
  sb_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [3:0] m_pc;
  logic [7:0] m_ir;
  logic [7:0] m_ret;
  logic       m_err;
  logic       m_halt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: each EXEC cycle that is about to retire consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!reset && en && ir_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_ir", ir, e.ir);
        check("sb_s", s, e.pc);
      end
    end
  end

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_ret = 0; m_err = 0; m_halt = 0;
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s"}, s, 0);
    check({tag, "_ir"}, ir, 0);
    check({tag, "_valid"}, ir_valid, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_err"}, addr_err, 0);
    check({tag, "_ret"}, retired, 0);
  endtask

  // Called just after an edge with the DUT in FETCH; leaves it just after the EXEC exit edge.
  task automatic instr(input logic jr, input logic jc, input logic [3:0] tgt, input logic h,
                       input int fstall, input int estall);
    sb_t e;
    e.pc = m_pc;
    e.ir = rom[m_pc];
    sb.push_back(e);
    if (fstall > 0) begin
      en = 1'b0;
      repeat (fstall) @(posedge clk);
      #1;
      check("fstall_s", s, m_pc);
      check("fstall_ir", ir, m_ir);
      check("fstall_valid", ir_valid, 0);
      check("fstall_ret", retired, m_ret);
      en = 1'b1;
    end
    @(posedge clk); #1;
    check("fetch_err_clr", addr_err, 0);
    m_ir = rom[m_pc];
    jump_req = jr; jump_cond = jc; jump_target = tgt; halt = h;
    if (estall > 0) begin
      en = 1'b0;
      repeat (estall) @(posedge clk);
      #1;
      check("estall_valid", ir_valid, 1);
      check("estall_ir", ir, m_ir);
      check("estall_s", s, m_pc);
      check("estall_ret", retired, m_ret);
      en = 1'b1;
    end
    @(posedge clk); #1;
    jump_req = 0; jump_cond = 0; jump_target = 0; halt = 0;
    if (m_ret != 8'hFF) m_ret = m_ret + 8'd1;
    m_err = 1'b0;
    if (h) begin
      m_halt = 1'b1;
    end else if (jr && jc) begin
      m_err = (tgt > 4'd9);
      m_pc  = m_err ? 4'd0 : tgt;
    end else begin
      m_pc = (m_pc == 4'd9) ? 4'd0 : m_pc + 4'd1;
    end
    check("exit_s", s, m_pc);
    check("exit_ret", retired, m_ret);
    check("exit_err", addr_err, m_err);
    check("exit_halted", halted, m_halt);
    check("exit_valid", ir_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rom[0] = 8'h08; rom[1] = 8'hF8; rom[2] = 8'h09; rom[3] = 8'hF9;
    rom[4] = 8'h0A; rom[5] = 8'hFA; rom[6] = 8'h0B; rom[7] = 8'hFB;
    rom[8] = 8'h0C; rom[9] = 8'hF0;
    for (int i = 10; i < 16; i++) rom[i] = 8'hE0 + 8'(i);

    reset = 1'b1; en = 1'b1;
    jump_req = 0; jump_cond = 0; jump_target = 0; halt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Sequential pass with wrap after address 9.
    for (int i = 0; i < 10; i++) instr(0, 0, 0, 0, 0, 0);
    check("pass_ret10", retired, 10);
    instr(0, 0, 0, 0, 0, 0);

    // Taken jump at pc 3 to 7, then untaken jump at pc 3.
    while (m_pc != 4'd3) instr(0, 0, 0, 0, 0, 0);
    instr(1, 1, 4'd7, 0, 0, 0);
    while (m_pc != 4'd3) instr(0, 0, 0, 0, 0, 0);
    instr(1, 0, 4'd7, 0, 0, 0);

    // Stalls during FETCH and EXEC.
    instr(0, 0, 0, 0, 3, 3);
    instr(0, 0, 0, 0, 0, 0);

    // Out-of-range target, target equal to LAST_ADDR, jump to self.
    instr(1, 1, 4'd12, 0, 0, 0);
    instr(1, 1, 4'd9, 0, 0, 0);
    instr(1, 1, 4'd9, 0, 0, 0);
    instr(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of EXEC at pc 6.
    while (m_pc != 4'd6) instr(0, 0, 0, 0, 0, 0);
    begin
      sb_t e;
      e.pc = m_pc; e.ir = rom[m_pc];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_exec");
    reset = 1'b0;
    model_reset();

    // Halt at pc 5 together with a taken jump.
    while (m_pc != 4'd5) instr(0, 0, 0, 0, 0, 0);
    instr(1, 1, 4'd2, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      jump_req = 1; jump_cond = 1; jump_target = 4'(i + 1); halt = 1'(i);
      @(posedge clk); #1;
      check("halt_s", s, 5);
      check("halt_valid", ir_valid, 0);
      check("halt_ret", retired, 6);
      check("halt_flag", halted, 1);
      check("halt_ir", ir, rom[5]);
    end
    jump_req = 0; jump_cond = 0; jump_target = 0; halt = 0;

    // Asynchronous reset while halted, then saturation of the retired count.
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_halt");
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 260; i++) instr(0, 0, 0, 0, 0, 0);
    check("ret_sat", retired, 255);

    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
